// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, condition codes,
// status flag bit positions and the sequencer state encoding.
package alu_seq_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_C      = 2'b10;
  localparam logic [1:0] COND_N      = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_DONE
  } state_t;

  // Opcodes 11x have no defined operation.
  function automatic logic is_illegal(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_cond_check.sv
// Decides whether an instruction runs, given its condition code and the
// sticky flags captured from earlier ADD/SUB results.
module alu_cond_check
  import alu_seq_pkg::*;
#(
  parameter int FLAG_W = 4
) (
  input  logic [1:0]        cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              execute
);

  // Overflow is tracked in the flag register but no condition tests it.
  logic unused_v;
  assign unused_v = flags[FLAG_V];

  always_comb begin
    execute = 1'b0;
    case (cond)
      COND_ALWAYS: execute = 1'b1;
      COND_Z:      execute = flags[FLAG_Z];
      COND_C:      execute = flags[FLAG_C];
      COND_N:      execute = flags[FLAG_N];
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Control-side sequencer for the ALU datapath: takes one instruction per
// handshake, steps it through LOAD/EXEC and returns the result with a done pulse.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        opcode,
  input  logic [1:0]        cond,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic              a_enable,
  output logic              acc_enable,
  output logic              addsub,
  output logic              xor_ctrl,
  output logic              mul_out_ctrl,
  input  logic [FLAG_W-1:0] status_reg,
  input  logic [WIDTH-1:0]  acc_out,
  input  logic [WIDTH-1:0]  mul_acc_out,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  result_hi,
  output logic [FLAG_W-1:0] flags,
  output logic              done,
  output logic              skipped,
  output logic              illegal
);

  state_t           state;
  state_t           state_next;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic             exec_q;
  logic             cond_ok;
  logic             accept;
  logic             runs;

  alu_cond_check #(
    .FLAG_W(FLAG_W)
  ) u_cond_check (
    .cond   (cond),
    .flags  (flags),
    .execute(cond_ok)
  );

  assign accept = instr_valid && instr_ready;
  // NOP, illegal opcodes and false conditions bypass LOAD/EXEC entirely.
  assign runs   = cond_ok && (is_alu_op(opcode) || (opcode == OP_LDA));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = runs ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: state_next = (op_q == OP_LDA) ? ST_DONE : ST_EXEC;
      ST_EXEC: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready  = (state == ST_IDLE);
    a_enable     = (state == ST_LOAD);
    acc_enable   = (state == ST_EXEC);
    addsub       = (state == ST_EXEC) && (op_q == OP_SUB);
    xor_ctrl     = (state == ST_EXEC) && (op_q == OP_XOR);
    mul_out_ctrl = (state == ST_EXEC) && (op_q == OP_MUL);
    done         = (state == ST_DONE);
  end

  // The ALU accumulator is loaded at the end of EXEC, so acc_out is only
  // meaningful during DONE; result is captured on the edge leaving DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= OP_NOP;
      b_q       <= '0;
      exec_q    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
      skipped   <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= opcode;
        b_q     <= op_b;
        exec_q  <= runs;
        skipped <= !cond_ok;
        illegal <= is_illegal(opcode);
        if (runs) begin
          alu_a <= op_a;
        end
      end
      if ((state == ST_LOAD) && (op_q != OP_LDA)) begin
        alu_b <= b_q;
      end
      if ((state == ST_EXEC) && ((op_q == OP_ADD) || (op_q == OP_SUB))) begin
        flags <= status_reg;
      end
      if ((state == ST_DONE) && exec_q) begin
        result    <= (op_q == OP_LDA) ? alu_a : acc_out;
        result_hi <= (op_q == OP_MUL) ? mul_acc_out : '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU that
// supplies acc_out, mul_acc_out and status_reg.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int WIDTH  = 16;
  localparam int FLAG_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        opcode;
  logic [1:0]        cond;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic              a_enable;
  logic              acc_enable;
  logic              addsub;
  logic              xor_ctrl;
  logic              mul_out_ctrl;
  logic [FLAG_W-1:0] status_reg;
  logic [WIDTH-1:0]  acc_out = '0;
  logic [WIDTH-1:0]  mul_acc_out = '0;
  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  result_hi;
  logic [FLAG_W-1:0] flags;
  logic              done;
  logic              skipped;
  logic              illegal;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(
    .WIDTH (WIDTH),
    .FLAG_W(FLAG_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .cond        (cond),
    .op_a        (op_a),
    .op_b        (op_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .a_enable    (a_enable),
    .acc_enable  (acc_enable),
    .addsub      (addsub),
    .xor_ctrl    (xor_ctrl),
    .mul_out_ctrl(mul_out_ctrl),
    .status_reg  (status_reg),
    .acc_out     (acc_out),
    .mul_acc_out (mul_acc_out),
    .result      (result),
    .result_hi   (result_hi),
    .flags       (flags),
    .done        (done),
    .skipped     (skipped),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add/sub status is combinational, accumulators are registered.
  logic [WIDTH:0]   sum_full;
  logic [2*WIDTH-1:0] prod;
  logic             ovf;
  always_comb begin
    if (addsub) begin
      sum_full = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
      ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (sum_full[WIDTH-1] != alu_a[WIDTH-1]);
    end else begin
      sum_full = {1'b0, alu_a} + {1'b0, alu_b};
      ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum_full[WIDTH-1] != alu_a[WIDTH-1]);
    end
    prod = 32'(alu_a) * 32'(alu_b);
    status_reg = {sum_full[WIDTH-1], (sum_full[WIDTH-1:0] == '0), sum_full[WIDTH], ovf};
  end

  always @(posedge clk) begin
    if (acc_enable) begin
      if (mul_out_ctrl) begin
        acc_out     <= prod[WIDTH-1:0];
        mul_acc_out <= prod[2*WIDTH-1:WIDTH];
      end else if (xor_ctrl) begin
        acc_out <= alu_a ^ alu_b;
      end else begin
        acc_out <= sum_full[WIDTH-1:0];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {a_enable, acc_enable, addsub, xor_ctrl, mul_out_ctrl};
  endfunction

  function automatic logic [3:0] hs();
    return {instr_ready, done, skipped, illegal};
  endfunction

  task automatic apply_stimulus(input logic [2:0] op, input logic [1:0] cd,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    instr_valid = 1'b1;
    opcode      = op;
    cond        = cd;
    op_a        = a;
    op_b        = b;
  endtask

  // Full ALU instruction: accept, LOAD, EXEC, DONE, back to IDLE.
  task automatic run_alu(input string tag, input logic [2:0] op, input logic [1:0] cd,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [4:0] exec_strobes, input logic [WIDTH-1:0] exp_res,
                         input logic [WIDTH-1:0] exp_hi, input logic [FLAG_W-1:0] exp_flags);
    apply_stimulus(op, cd, a, b);
    check_output({tag, ".ready"}, 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
    opcode = OP_NOP;
    op_a = ~a;
    op_b = ~b;
    check_output({tag, ".load_strobes"}, 32'(strobes()), 32'(5'b10000));
    check_output({tag, ".load_alu_a"}, 32'(alu_a), 32'(a));
    check_output({tag, ".load_hs"}, 32'(hs()), 32'(4'b0000));
    tick();
    check_output({tag, ".exec_strobes"}, 32'(strobes()), 32'(exec_strobes));
    check_output({tag, ".exec_alu_b"}, 32'(alu_b), 32'(b));
    tick();
    check_output({tag, ".done_hs"}, 32'(hs()), 32'(4'b0100));
    check_output({tag, ".done_strobes"}, 32'(strobes()), 32'(5'b00000));
    check_output({tag, ".flags"}, 32'(flags), 32'(exp_flags));
    tick();
    check_output({tag, ".result"}, 32'(result), 32'(exp_res));
    check_output({tag, ".result_hi"}, 32'(result_hi), 32'(exp_hi));
    check_output({tag, ".idle_hs"}, 32'(hs() & 4'b1100), 32'(4'b1000));
  endtask

  // Instruction that goes straight from accept to DONE.
  task automatic run_short(input string tag, input logic [2:0] op, input logic [1:0] cd,
                           input logic [3:0] exp_hs, input logic [WIDTH-1:0] exp_res);
    apply_stimulus(op, cd, 16'h5A5A, 16'hA5A5);
    tick();
    instr_valid = 1'b0;
    check_output({tag, ".done_hs"}, 32'(hs()), 32'(exp_hs));
    check_output({tag, ".strobes"}, 32'(strobes()), 32'(5'b00000));
    tick();
    check_output({tag, ".ready_back"}, 32'(hs() & 4'b1100), 32'(4'b1000));
    check_output({tag, ".result_held"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    opcode = OP_NOP;
    cond = COND_ALWAYS;
    op_a = '0;
    op_b = '0;
    #2 rst = 1'b0;
    #1;
    check_output("reset.hs", 32'(hs()), 32'(4'b1000));
    check_output("reset.strobes", 32'(strobes()), 32'(5'b00000));
    check_output("reset.flags", 32'(flags), 32'd0);
    check_output("reset.result", 32'({result, result_hi}), 32'd0);
    check_output("reset.alu", 32'({alu_a, alu_b}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    run_alu("add1", OP_ADD, COND_ALWAYS, 16'h0003, 16'h0004, 5'b01000, 16'h0007, 16'h0000, 4'b0000);
    run_alu("sub1", OP_SUB, COND_ALWAYS, 16'h0005, 16'h0005, 5'b01100, 16'h0000, 16'h0000, 4'b0110);
    run_alu("mul1", OP_MUL, COND_ALWAYS, 16'h0100, 16'h0100, 5'b01001, 16'h0000, 16'h0001, 4'b0110);
    run_alu("xor_ifc", OP_XOR, COND_C, 16'h00FF, 16'h0F0F, 5'b01010, 16'h0FF0, 16'h0000, 4'b0110);
    run_alu("add_ifz", OP_ADD, COND_Z, 16'h0001, 16'h0002, 5'b01000, 16'h0003, 16'h0000, 4'b0000);
    run_short("skip_ifz", OP_ADD, COND_Z, 4'b0110, 16'h0003);
    run_short("illegal", 3'b111, COND_ALWAYS, 4'b0101, 16'h0003);
    run_short("nop", OP_NOP, COND_ALWAYS, 4'b0100, 16'h0003);

    // LDA with instr_valid held high throughout two instructions.
    apply_stimulus(OP_LDA, COND_ALWAYS, 16'hBEEF, 16'h1111);
    tick();
    op_a = 16'h1234;
    check_output("lda.load_strobes", 32'(strobes()), 32'(5'b10000));
    check_output("lda.load_alu_a", 32'(alu_a), 32'h0000BEEF);
    tick();
    check_output("lda.done_hs", 32'(hs()), 32'(4'b0100));
    check_output("lda.done_strobes", 32'(strobes()), 32'(5'b00000));
    tick();
    check_output("lda.idle_hs", 32'(hs() & 4'b1100), 32'(4'b1000));
    check_output("lda.result", 32'(result), 32'h0000BEEF);
    check_output("lda.result_hi", 32'(result_hi), 32'd0);
    tick();
    instr_valid = 1'b0;
    check_output("lda2.accepted", 32'(hs()), 32'(4'b0000));
    check_output("lda2.alu_a", 32'(alu_a), 32'h00001234);
    tick();
    check_output("lda2.done_hs", 32'(hs()), 32'(4'b0100));
    tick();
    check_output("lda2.result", 32'(result), 32'h00001234);
    check_output("lda2.flags", 32'(flags), 32'd0);

    run_alu("sub_neg", OP_SUB, COND_ALWAYS, 16'h0001, 16'h0002, 5'b01100, 16'hFFFF, 16'h0000, 4'b1000);

    // Reset asserted while the instruction sits in EXEC.
    apply_stimulus(OP_ADD, COND_ALWAYS, 16'h0010, 16'h0020);
    tick();
    instr_valid = 1'b0;
    tick();
    check_output("rst_mid.exec_strobes", 32'(strobes()), 32'(5'b01000));
    #2 rst = 1'b0;
    #1;
    check_output("rst_mid.hs", 32'(hs()), 32'(4'b1000));
    check_output("rst_mid.strobes", 32'(strobes()), 32'(5'b00000));
    check_output("rst_mid.flags", 32'(flags), 32'd0);
    check_output("rst_mid.result", 32'({result, result_hi}), 32'd0);
    check_output("rst_mid.alu", 32'({alu_a, alu_b}), 32'd0);
    tick();
    check_output("rst_mid.no_done", 32'(hs()), 32'(4'b1000));
    rst = 1'b1;
    run_alu("add_after_rst", OP_ADD, COND_ALWAYS, 16'h0010, 16'h0020, 5'b01000, 16'h0030, 16'h0000, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
